mem_access_unit: RTL and testbench

Load/store initiator that drives the team's synchronous block RAM on behalf of the RV32I core.
- Accepts one byte-addressed load or store request at a time.
- Converts it to a word address, byte-lane write enables and replicated write data.
- For loads, issues a 1-cycle-latency registered read, then extracts, aligns and sign/zero-extends the result.
- Returns a one-cycle response pulse; flags misaligned or invalid accesses without touching memory.

---
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and block-RAM bus bundle for mem_access_unit.
// slave = the unit itself, master = the core/requester side that also models the RAM.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_write;
  logic [2:0]            i_req_funct3;
  logic [ADDR_WIDTH:0]   i_req_addr;
  logic [DATA_WIDTH:0]   i_req_wdata;
  logic                  o_resp_valid;
  logic [DATA_WIDTH:0]   o_resp_rdata;
  logic                  o_resp_error;
  logic                  o_read_enable;
  logic [ADDR_WIDTH:0]   o_read_addr;
  logic [DATA_WIDTH:0]   i_read_data;
  logic [3:0]            o_write_enable;
  logic [ADDR_WIDTH:0]   o_write_addr;
  logic [DATA_WIDTH:0]   o_write_data;

  modport slave (
    input  i_req_valid, i_req_write, i_req_funct3, i_req_addr, i_req_wdata, i_read_data,
    output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_error,
           o_read_enable, o_read_addr, o_write_enable, o_write_addr, o_write_data
  );

  modport master (
    output i_req_valid, i_req_write, i_req_funct3, i_req_addr, i_req_wdata, i_read_data,
    input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_error,
           o_read_enable, o_read_addr, o_write_enable, o_write_addr, o_write_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I load/store initiator for a 1-cycle-latency synchronous block RAM.
// One access in flight; every output is a register.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  mem_access_unit_if.slave   bus_io
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          offset_q, offset_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH:0] resp_rdata_q, resp_rdata_d;
  logic                resp_error_q, resp_error_d;
  logic                read_enable_q, read_enable_d;
  logic [ADDR_WIDTH:0] read_addr_q, read_addr_d;
  logic [3:0]          write_enable_q, write_enable_d;
  logic [ADDR_WIDTH:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH:0] write_data_q, write_data_d;

  logic [ADDR_WIDTH:0] word_addr;
  logic                accept;

  // Invalid encodings and misalignment; unsigned sizes make no sense for stores.
  function automatic logic req_error(input logic wr, input logic [2:0] f3, input logic [1:0] off);
    logic err;
    case (f3)
      3'b000:  err = 1'b0;
      3'b001:  err = off[0];
      3'b010:  err = (off != 2'b00);
      3'b100:  err = wr;
      3'b101:  err = wr | off[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [DATA_WIDTH:0] lane_replicate(input logic [2:0] f3,
                                                         input logic [DATA_WIDTH:0] wd);
    logic [DATA_WIDTH:0] r;
    case (f3[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_WIDTH:0] load_align(input logic [DATA_WIDTH:0] raw,
                                                     input logic [2:0] f3,
                                                     input logic [1:0] off);
    logic [DATA_WIDTH:0] s;
    logic [DATA_WIDTH:0] r;
    s = raw >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{(DATA_WIDTH - 7){s[7]}}, s[7:0]};
      3'b100:  r = {{(DATA_WIDTH - 7){1'b0}}, s[7:0]};
      3'b001:  r = {{(DATA_WIDTH - 15){s[15]}}, s[15:0]};
      3'b101:  r = {{(DATA_WIDTH - 15){1'b0}}, s[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  assign word_addr = {2'b00, bus_io.i_req_addr[ADDR_WIDTH:2]};
  assign accept    = req_ready_q & bus_io.i_req_valid;

  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    funct3_d       = funct3_q;
    offset_d       = offset_q;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = resp_rdata_q;
    resp_error_d   = resp_error_q;
    read_enable_d  = 1'b0;
    read_addr_d    = read_addr_q;
    write_enable_d = 4'b0000;
    write_addr_d   = write_addr_q;
    write_data_d   = write_data_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d  = bus_io.i_req_write;
          funct3_d = bus_io.i_req_funct3;
          offset_d = bus_io.i_req_addr[1:0];
          if (req_error(bus_io.i_req_write, bus_io.i_req_funct3, bus_io.i_req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_error_d = 1'b1;
          end else begin
            // RAM-facing outputs are loaded here so they are live during ISSUE.
            state_d      = ISSUE;
            read_addr_d  = word_addr;
            write_addr_d = word_addr;
            if (bus_io.i_req_write) begin
              write_enable_d = lane_mask(bus_io.i_req_funct3, bus_io.i_req_addr[1:0]);
              write_data_d   = lane_replicate(bus_io.i_req_funct3, bus_io.i_req_wdata);
            end else begin
              read_enable_d = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (write_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_error_d = 1'b0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_align(bus_io.i_read_data, funct3_q, offset_q);
        resp_error_d = 1'b0;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      write_q        <= 1'b0;
      funct3_q       <= 3'b000;
      offset_q       <= 2'b00;
      req_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_error_q   <= 1'b0;
      read_enable_q  <= 1'b0;
      read_addr_q    <= '0;
      write_enable_q <= 4'b0000;
      write_addr_q   <= '0;
      write_data_q   <= '0;
    end else if (clk_en) begin
      state_q        <= state_d;
      write_q        <= write_d;
      funct3_q       <= funct3_d;
      offset_q       <= offset_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_error_q   <= resp_error_d;
      read_enable_q  <= read_enable_d;
      read_addr_q    <= read_addr_d;
      write_enable_q <= write_enable_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
    end
  end

  assign bus_io.o_req_ready    = req_ready_q;
  assign bus_io.o_resp_valid   = resp_valid_q;
  assign bus_io.o_resp_rdata   = resp_rdata_q;
  assign bus_io.o_resp_error   = resp_error_q;
  assign bus_io.o_read_enable  = read_enable_q;
  assign bus_io.o_read_addr    = read_addr_q;
  assign bus_io.o_write_enable = write_enable_q;
  assign bus_io.o_write_addr   = write_addr_q;
  assign bus_io.o_write_data   = write_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small byte-enabled 1-cycle-latency RAM model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) bus ();

  mem_access_unit #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus_io (bus)
  );

  // RAM model sharing the clock enable
  logic [31:0] mem [0:255];
  logic [31:0] ram_q = 32'h0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  end

  always @(posedge clk) begin
    if (clk_en) begin
      if (bus.o_read_enable) ram_q <= mem[bus.o_read_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (bus.o_write_enable[b]) mem[bus.o_write_addr[7:0]][8*b +: 8] <= bus.o_write_data[8*b +: 8];
    end
  end

  assign bus.i_read_data = ram_q;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic do_req(input int tag, input vec_t v);
    int lat;
    int pulses;
    int n;
    int exp_lat;
    bit seen_en;
    lat = 0; pulses = 0; n = 0; seen_en = 0;
    while (!bus.o_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d ready", tag), {31'b0, bus.o_req_ready}, 32'h1);
    bus.i_req_valid  = 1'b1;
    bus.i_req_write  = v.wr;
    bus.i_req_funct3 = v.f3;
    bus.i_req_addr   = v.addr;
    bus.i_req_wdata  = v.wdata;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus.i_req_valid = 1'b0;
      if (bus.o_read_enable || bus.o_write_enable != 4'b0) seen_en = 1'b1;
      if (k == 1 && !v.err) begin
        if (v.wr) begin
          chk($sformatf("v%0d we", tag), {28'b0, bus.o_write_enable}, {28'b0, v.we});
          chk($sformatf("v%0d waddr", tag), bus.o_write_addr, v.addr >> 2);
          chk($sformatf("v%0d wdata", tag), bus.o_write_data, v.wd);
        end else begin
          chk($sformatf("v%0d re", tag), {31'b0, bus.o_read_enable}, 32'h1);
          chk($sformatf("v%0d raddr", tag), bus.o_read_addr, v.addr >> 2);
        end
      end
      if (bus.o_resp_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          chk($sformatf("v%0d rdata", tag), bus.o_resp_rdata, v.rd);
          chk($sformatf("v%0d error", tag), {31'b0, bus.o_resp_error}, {31'b0, v.err});
        end
      end
    end
    exp_lat = v.err ? 1 : (v.wr ? 2 : 3);
    chk($sformatf("v%0d latency", tag), lat, exp_lat);
    chk($sformatf("v%0d pulses", tag), pulses, 1);
    if (v.err) chk($sformatf("v%0d no_ram_en", tag), {31'b0, seen_en}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vec_t v;
    vt[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
    vt[1]  = '{1'b0, 3'b010, 32'h100, 32'h0,       1'b0, 4'b0000, 32'h0,       32'hDEADBEEF};
    vt[2]  = '{1'b1, 3'b000, 32'h102, 32'h000000F0, 1'b0, 4'b0100, 32'hF0F0F0F0, 32'h0};
    vt[3]  = '{1'b0, 3'b000, 32'h102, 32'h0,       1'b0, 4'b0000, 32'h0,       32'hFFFFFFF0};
    vt[4]  = '{1'b0, 3'b100, 32'h102, 32'h0,       1'b0, 4'b0000, 32'h0,       32'h000000F0};
    vt[5]  = '{1'b1, 3'b001, 32'h106, 32'h00008001, 1'b0, 4'b1100, 32'h80018001, 32'h0};
    vt[6]  = '{1'b0, 3'b001, 32'h106, 32'h0,       1'b0, 4'b0000, 32'h0,       32'hFFFF8001};
    vt[7]  = '{1'b0, 3'b101, 32'h106, 32'h0,       1'b0, 4'b0000, 32'h0,       32'h00008001};
    vt[8]  = '{1'b0, 3'b010, 32'h105, 32'h0,       1'b1, 4'b0000, 32'h0,       32'h0};
    vt[9]  = '{1'b0, 3'b011, 32'h100, 32'h0,       1'b1, 4'b0000, 32'h0,       32'h0};
    vt[10] = '{1'b1, 3'b100, 32'h100, 32'h12345678, 1'b1, 4'b0000, 32'h0,       32'h0};
    vt[11] = '{1'b0, 3'b001, 32'h101, 32'h0,       1'b1, 4'b0000, 32'h0,       32'h0};
    vt[12] = '{1'b0, 3'b000, 32'h101, 32'h0,       1'b0, 4'b0000, 32'h0,       32'hFFFFFFBE};
    vt[13] = '{1'b0, 3'b100, 32'h103, 32'h0,       1'b0, 4'b0000, 32'h0,       32'h000000DE};
    vt[14] = '{1'b0, 3'b001, 32'h100, 32'h0,       1'b0, 4'b0000, 32'h0,       32'hFFFFBEEF};

    rst = 1'b1;
    clk_en = 1'b1;
    bus.i_req_valid  = 1'b0;
    bus.i_req_write  = 1'b0;
    bus.i_req_funct3 = 3'b000;
    bus.i_req_addr   = 32'h0;
    bus.i_req_wdata  = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst ready", {31'b0, bus.o_req_ready}, 32'h0);
    chk("rst resp_valid", {31'b0, bus.o_resp_valid}, 32'h0);
    chk("rst we", {28'b0, bus.o_write_enable}, 32'h0);
    chk("rst re", {31'b0, bus.o_read_enable}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst ready", {31'b0, bus.o_req_ready}, 32'h1);

    for (int i = 0; i < 15; i++) do_req(i, vt[i]);

    // Reset while a load is waiting on RAM data: the access is dropped.
    @(negedge clk);
    bus.i_req_valid  = 1'b1;
    bus.i_req_write  = 1'b0;
    bus.i_req_funct3 = 3'b010;
    bus.i_req_addr   = 32'h100;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    chk("rstmid re", {31'b0, bus.o_read_enable}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid resp_valid", {31'b0, bus.o_resp_valid}, 32'h0);
    chk("rstmid rdata", bus.o_resp_rdata, 32'h0);
    chk("rstmid raddr", bus.o_read_addr, 32'h0);
    chk("rstmid wdata", bus.o_write_data, 32'h0);
    chk("rstmid ready", {31'b0, bus.o_req_ready}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid ready_after", {31'b0, bus.o_req_ready}, 32'h1);
    chk("rstmid no_resp", {31'b0, bus.o_resp_valid}, 32'h0);
    v = '{1'b0, 3'b010, 32'h104, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h80010000};
    do_req(100, v);

    // Clock enable dropped for three cycles while a load is in ISSUE.
    @(negedge clk);
    bus.i_req_valid  = 1'b1;
    bus.i_req_write  = 1'b0;
    bus.i_req_funct3 = 3'b010;
    bus.i_req_addr   = 32'h100;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    clk_en = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("ce c%0d re", k), {31'b0, bus.o_read_enable}, 32'h1);
      chk($sformatf("ce c%0d resp", k), {31'b0, bus.o_resp_valid}, 32'h0);
    end
    clk_en = 1'b1;
    lat = 0;
    for (int k = 5; k <= 9; k++) begin
      @(negedge clk);
      if (bus.o_resp_valid && lat == 0) begin
        lat = k;
        chk("ce rdata", bus.o_resp_rdata, 32'hDEF0BEEF);
      end
    end
    chk("ce latency", lat, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
